// File: rtl/data_mem_resp.sv
// Data-memory responder: word-organised RAM serving one load/store at a time.
// Loads return the extended lane with ack in the cycle after the request edge.
module data_mem_resp #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  func3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRd, StWrAck, StErr} state_e;

  state_e state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          illegal, misaligned, bad, accept, mem_we;
  logic [3:0]    wmask;
  logic [31:0]   wlanes;
  logic [31:0]   rword, rext;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rdata_q;
  logic          unused_addr;

  assign idx = addr[AW+1:2];
  assign off = addr[1:0];

  // Addresses wrap modulo DEPTH*4, so the upper bits are deliberately dropped.
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    illegal = 1'b0;
    unique case (func3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = we;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((func3[1:0] == 2'b01) && off[0]) ||
                 ((func3[1:0] == 2'b10) && (off != 2'b00));
  end

  assign bad    = illegal | misaligned;
  assign accept = (state_q == StIdle) && req;
  // Gate on rst so a request coinciding with reset leaves the RAM untouched.
  assign mem_we = accept && we && !bad && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (bad)     state_d = StErr;
          else if (we) state_d = StWrAck;
          else         state_d = StRd;
        end
      end
      StRd, StWrAck, StErr: state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  always_comb begin
    ack  = (state_q == StRd) || (state_q == StWrAck);
    err  = (state_q == StErr);
    busy = (state_q != StIdle);
  end

  always_comb begin
    wmask  = 4'b1111;
    wlanes = wdata;
    unique case (func3[1:0])
      2'b00: begin
        wmask  = 4'b0001 << off;
        wlanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        wmask  = off[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
      end
      default: begin
        wmask  = 4'b1111;
        wlanes = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    rword = mem[idx];
    rbyte = rword[{off, 3'b000} +: 8];
    rhalf = off[1] ? rword[31:16] : rword[15:0];
    unique case (func3)
      3'b000:  rext = {{24{rbyte[7]}}, rbyte};
      3'b001:  rext = {{16{rhalf[15]}}, rhalf};
      3'b100:  rext = {24'h0, rbyte};
      3'b101:  rext = {16'h0, rhalf};
      default: rext = rword;
    endcase
  end

  // The extended result is captured at the request edge so it is valid during RD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= 32'h0;
    end else if (accept && !we && !bad) begin
      rdata_q <= rext;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: a byte-addressed model predicts every
// ack/err response and a negedge monitor checks them as they appear.
module tb_data_mem_resp;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [2:0]  func3 = 3'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ack, err, busy;

  data_mem_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .func3(func3),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cycle  = 0;
  logic [7:0]  mbytes [DEPTH*4];
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && (ack || err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {30'h0, ack, err}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("resp_kind", {30'h0, ack, err}, e.is_err ? 32'h1 : 32'h2);
        chk("rdata", rdata, e.data);
        chk("latency", cycle, e.cyc);
      end
    end
  end

  // Byte-level reference: stores write n bytes, loads gather n bytes and extend.
  function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, output bit is_err,
                                output logic [31:0] data);
    int n;
    int base;
    logic [31:0] v;
    base = int'(a % (DEPTH * 4));
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (w && f3[2])) begin
      is_err = 1'b1; data = last_rdata; return;
    end
    n = 1 << f3[1:0];
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
      is_err = 1'b1; data = last_rdata; return;
    end
    is_err = 1'b0;
    if (w) begin
      for (int k = 0; k < n; k++) mbytes[base + k] = d[8*k +: 8];
      data = last_rdata;
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[base + k];
      if (!f3[2] && n < 4 && v[8*n-1]) begin
        for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      end
      last_rdata = v;
      data = v;
    end
  endfunction

  task automatic wait_idle();
    int i;
    @(negedge clk);
    i = 0;
    while (busy && i < 10) begin
      @(negedge clk);
      i++;
    end
    if (busy) chk("busy_stuck", {31'h0, busy}, 32'h0);
  endtask

  task automatic push_exp(bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    exp_t e;
    model(w, f3, a, d, e.is_err, e.data);
    e.cyc = cycle + 1;
    sb.push_back(e);
  endtask

  task automatic issue(bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int i;
    wait_idle();
    push_exp(w, f3, a, d);
    req = 1'b1; we = w; func3 = f3; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    i = 0;
    while (sb.size() != 0 && i < 6) begin
      @(posedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    bit          rw;
    logic [2:0]  rf3;
    logic [31:0] ra;

    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_err", {31'h0, err}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;

    // Word round trip, lane merge and extension.
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_roundtrip", rdata, 32'hDEADBEEF);
    issue(1'b1, 3'b000, 32'h11, 32'h000000A5);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("sb_merge", rdata, 32'hDEADA5EF);
    issue(1'b0, 3'b000, 32'h11, 32'h0);
    chk("lb_sext", rdata, 32'hFFFFFFA5);
    issue(1'b0, 3'b100, 32'h11, 32'h0);
    chk("lbu_zext", rdata, 32'h000000A5);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh_sext", rdata, 32'hFFFFDEAD);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    chk("lhu_zext", rdata, 32'h0000DEAD);

    // Misaligned and illegal accesses; rdata must hold across err.
    issue(1'b0, 3'b010, 32'h13, 32'h0);
    chk("err_holds_rdata", rdata, 32'h0000DEAD);
    issue(1'b1, 3'b001, 32'h11, 32'h0000FFFF);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b100, 32'h10, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("word_unchanged", rdata, 32'hDEADA5EF);

    // req held through RD with another address must yield a single ack.
    wait_idle();
    push_exp(1'b0, 3'b010, 32'h10, 32'h0);
    req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    chk("busy_in_rd", {31'h0, busy}, 32'h1);
    addr = 32'h4;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_single_ack", sb.size(), 32'h0);
    sb.delete();

    // Address wrap modulo DEPTH*4.
    issue(1'b1, 3'b010, DEPTH * 4 + 32'h4, 32'hCAFEF00D);
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    chk("wrap_lw", rdata, 32'hCAFEF00D);

    // Reset during RD aborts the load.
    issue(1'b1, 3'b010, 32'h20, 32'h12345678);
    wait_idle();
    req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'h20;
    @(posedge clk);
    #1 rst = 1'b0;
    req = 1'b0;
    #1;
    chk("rst_mid_ack", {31'h0, ack}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    last_rdata = 32'h0;
    @(negedge clk);
    chk("rst_mid_no_ack", {31'h0, ack}, 32'h0);
    rst = 1'b1;
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    chk("rst_reload", rdata, 32'h12345678);

    // Randomised traffic over a 16-word window with random wrap bits.
    for (int w = 0; w < 16; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom);
    for (int n = 0; n < 300; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      ra[11:6] = 6'h0;
      issue(rw, rf3, ra, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder for the core's load/store path: the far end of the LOAD/STORE traffic that ctrl sequences with its two-phase load.
- Holds a word-organised RAM and accepts one request at a time (address, write flag, func3 access type).
- Stores: byte/half/word lane merging. Loads: result is sign- or zero-extended and returned one cycle after the request, which matches the core's load_phase write-back slot.
- Sits between the core's mem_addr_sel output and the rd_mux RD_MEM input.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM (power of two).
- AW, 10, word-index width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; qualified by req.
- addr  input  32  byte address.
- func3  input  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  output  32  extended load result.
- ack  output  1  one-cycle completion pulse for load or store.
- err  output  1  one-cycle pulse on misaligned or illegal access.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Word index = addr[AW+1:2]. Address bits above AW+1 are ignored, so addresses wrap modulo DEPTH*4. Byte offset = addr[1:0].
- Reset (rst=0, asynchronous):
  - state -> IDLE; rdata=0, ack=0, err=0, busy=0.
  - RAM contents are not cleared.
  - A reset during RD or WR_ACK aborts the access: no ack, no partial write beyond any edge already taken.
- FSM states: IDLE, RD, WR_ACK, ERR.
- IDLE, req=0: stay; ack=0, err=0.
- IDLE, req=1, access illegal or misaligned: go to ERR; no RAM write; rdata unchanged.
  - Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal = func3 011/110/111, or a store with func3 100/101.
- IDLE, req=1, we=0, legal: register the RAM word and offset/func3 at this edge; go to RD.
- RD (exactly one cycle):
  - rdata = selected lane, extended: LB/LH sign-extend, LBU/LHU zero-extend, LW raw word.
  - ack=1, busy=1; next state IDLE.
  - Total load latency: req edge -> rdata valid with ack in the following cycle.
- IDLE, req=1, we=1, legal: merge wdata into the addressed lanes at this edge; go to WR_ACK.
  - SB writes byte lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all four.
  - Unaddressed lanes are preserved.
- WR_ACK: ack=1 for one cycle; rdata holds its previous value; next state IDLE.
- ERR: err=1, ack=0 for one cycle; next state IDLE.
- req asserted while busy=1 is ignored and not queued. The core re-presents the request after busy falls.
- Back-to-back requests: the earliest a new request is accepted is the cycle after ack/err, i.e. a throughput of one access per 2 cycles.
- Read-after-write to the same address: the load issued after WR_ACK returns the merged data.
- rdata is registered and holds its last load value until the next RD cycle.

Test Plan:
- Reset mid-load: issue LW, drop rst=0 during RD -> ack never pulses, rdata=0, busy=0, state IDLE. After release, the same LW returns the stored word.
- Word round trip: SW addr=0x10 wdata=0xDEADBEEF -> ack in cycle 2. Then LW 0x10 -> cycle-2 rdata=0xDEADBEEF, ack=1.
- Lane merge and extension: with word 0x10=0xDEADBEEF:
  - SB addr=0x11 wdata=0x000000A5 -> word becomes 0xDEADA5EF.
  - LB 0x11 -> 0xFFFFFFA5.
  - LBU 0x11 -> 0x000000A5.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x12 -> 0x0000DEAD.
- Misalignment and illegal codes:
  - LW 0x13 -> err pulse, no ack.
  - SH 0x11 wdata=0xFFFF -> err, word unchanged.
  - func3=011 -> err.
- Busy handling and wrap: hold req=1 during RD with a different address -> ignored, only one ack. Then SW addr=DEPTH*4+0x4 followed by LW 0x4 returns the written data (wrap-around).
